// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared states, opcodes and encodings for the multi-cycle control unit
package cu_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_ACC,
    S_TRAP
  } cu_state_e;

  typedef enum logic [3:0] {
    CL_NOP,
    CL_ALU,
    CL_LOAD,
    CL_STORE,
    CL_BR_EQ,
    CL_BR_NE,
    CL_JUMP,
    CL_CALL,
    CL_RET,
    CL_ACC,
    CL_ILLEGAL
  } op_class_e;

  localparam logic [4:0] OP_NOP       = 5'b00000;
  localparam logic [4:0] OP_ALU_FIRST = 5'b00001;
  localparam logic [4:0] OP_ALU_LAST  = 5'b01010;
  localparam logic [4:0] OP_BEQ       = 5'b01011;
  localparam logic [4:0] OP_BNE       = 5'b01100;
  localparam logic [4:0] OP_JUMP      = 5'b01101;
  localparam logic [4:0] OP_CALL      = 5'b01110;
  localparam logic [4:0] OP_RET       = 5'b01111;
  localparam logic [4:0] OP_LOAD      = 5'b10000;
  localparam logic [4:0] OP_STORE     = 5'b10001;
  localparam logic [4:0] OP_FFT       = 5'b10010;
  localparam logic [4:0] OP_ENCRYPT   = 5'b10011;
  localparam logic [4:0] OP_DECRYPT   = 5'b10100;

  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_TARGET = 2'd1;
  localparam logic [1:0] PC_RETURN = 2'd2;

  localparam logic [1:0] ACC_FFT     = 2'd0;
  localparam logic [1:0] ACC_ENCRYPT = 2'd1;
  localparam logic [1:0] ACC_DECRYPT = 2'd2;

  localparam logic [1:0] TC_NONE    = 2'd0;
  localparam logic [1:0] TC_ILLEGAL = 2'd1;
  localparam logic [1:0] TC_STACK   = 2'd2;
  localparam logic [1:0] TC_TIMEOUT = 2'd3;

endpackage

// File: rtl/cu_opcode_classifier.sv
// rtl/cu_opcode_classifier.sv - combinational opcode to instruction-class decode
module cu_opcode_classifier
  import cu_pkg::*;
#(
  parameter int OPCODE_W = 5
) (
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_e           op_class,
  output logic [1:0]          acc_sel
);

  logic [4:0] op5;
  logic       upper_set;

  // Any bit above the 5-bit opcode space makes the instruction illegal
  assign op5       = opcode[4:0];
  assign upper_set = (opcode >> 5) != '0;

  // Map the low opcode bits onto an instruction class and accelerator function
  always_comb begin
    op_class = CL_ILLEGAL;
    acc_sel  = ACC_FFT;
    if (!upper_set) begin
      case (op5)
        OP_NOP:     op_class = CL_NOP;
        OP_BEQ:     op_class = CL_BR_EQ;
        OP_BNE:     op_class = CL_BR_NE;
        OP_JUMP:    op_class = CL_JUMP;
        OP_CALL:    op_class = CL_CALL;
        OP_RET:     op_class = CL_RET;
        OP_LOAD:    op_class = CL_LOAD;
        OP_STORE:   op_class = CL_STORE;
        OP_FFT:     begin op_class = CL_ACC; acc_sel = ACC_FFT;     end
        OP_ENCRYPT: begin op_class = CL_ACC; acc_sel = ACC_ENCRYPT; end
        OP_DECRYPT: begin op_class = CL_ACC; acc_sel = ACC_DECRYPT; end
        default: begin
          if (op5 >= OP_ALU_FIRST && op5 <= OP_ALU_LAST) op_class = CL_ALU;
        end
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - FETCH/DECODE/EXEC/MEM/WB sequencer with call-depth and trap tracking
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int OPCODE_W    = 5,
  parameter int STACK_DEPTH = 8,
  parameter int ACC_TIMEOUT = 255,
  parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero_flag,
  input  logic                mem_ready,
  input  logic                acc_done,
  output logic                ir_load,
  output logic                register_write,
  output logic                memory_read,
  output logic                memory_write,
  output logic                alu_source,
  output logic                memory_to_register,
  output logic                pc_write,
  output logic [1:0]          pc_sel,
  output logic                stack_push,
  output logic                stack_pop,
  output logic                acc_start,
  output logic [1:0]          acc_sel,
  output logic [DEPTH_W-1:0]  call_depth,
  output logic                trap,
  output logic [1:0]          trap_cause
);

  localparam int CNT_W = $clog2(ACC_TIMEOUT + 1);

  cu_state_e            state_q, state_d;
  logic [OPCODE_W-1:0]  opcode_q;
  op_class_e            class_q, dec_class;
  logic [1:0]           acc_sel_q, dec_acc_sel;
  logic [DEPTH_W-1:0]   depth_q;
  logic [CNT_W-1:0]     acc_cnt_q;
  logic [1:0]           cause_q, cause_d;

  cu_opcode_classifier #(.OPCODE_W(OPCODE_W)) u_classifier (
    .opcode   (opcode_q),
    .op_class (dec_class),
    .acc_sel  (dec_acc_sel)
  );

  assign call_depth = depth_q;
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;

  // Next state and per-state strobes; everything keyed off the registered state
  always_comb begin
    state_d            = state_q;
    cause_d            = cause_q;
    ir_load            = 1'b0;
    register_write     = 1'b0;
    memory_read        = 1'b0;
    memory_write       = 1'b0;
    alu_source         = 1'b0;
    memory_to_register = 1'b0;
    pc_write           = 1'b0;
    pc_sel             = PC_INC;
    stack_push         = 1'b0;
    stack_pop          = 1'b0;
    acc_start          = 1'b0;
    acc_sel            = ACC_FFT;
    case (state_q)
      S_FETCH: begin
        // Gated so the IR strobe stays quiet while reset is held
        ir_load = instr_valid & rst_n;
        if (instr_valid) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (dec_class)
          CL_NOP:     begin pc_write = 1'b1; state_d = S_FETCH; end
          CL_ILLEGAL: begin cause_d = TC_ILLEGAL; state_d = S_TRAP; end
          CL_ACC:     state_d = S_ACC;
          default:    state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (class_q)
          CL_ALU:   state_d = S_WB;
          CL_LOAD,
          CL_STORE: begin alu_source = 1'b1; state_d = S_MEM; end
          CL_BR_EQ: begin pc_write = 1'b1; pc_sel = zero_flag ? PC_TARGET : PC_INC; end
          CL_BR_NE: begin pc_write = 1'b1; pc_sel = zero_flag ? PC_INC : PC_TARGET; end
          CL_JUMP:  begin pc_write = 1'b1; pc_sel = PC_TARGET; end
          CL_CALL: begin
            if (depth_q == DEPTH_W'(STACK_DEPTH)) begin
              cause_d = TC_STACK;
              state_d = S_TRAP;
            end else begin
              stack_push = 1'b1;
              pc_write   = 1'b1;
              pc_sel     = PC_TARGET;
            end
          end
          CL_RET: begin
            if (depth_q == '0) begin
              cause_d = TC_STACK;
              state_d = S_TRAP;
            end else begin
              stack_pop = 1'b1;
              pc_write  = 1'b1;
              pc_sel    = PC_RETURN;
            end
          end
          default: ;
        endcase
      end
      S_MEM: begin
        alu_source   = 1'b1;
        memory_read  = (class_q == CL_LOAD);
        memory_write = (class_q == CL_STORE);
        if (mem_ready) begin
          if (class_q == CL_LOAD) begin
            state_d = S_WB;
          end else begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end
        end
      end
      S_ACC: begin
        acc_sel   = acc_sel_q;
        acc_start = (acc_cnt_q == '0);
        if (acc_done) begin
          state_d = S_WB;
        end else if (acc_cnt_q == CNT_W'(ACC_TIMEOUT)) begin
          cause_d = TC_TIMEOUT;
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        register_write     = 1'b1;
        memory_to_register = (class_q == CL_LOAD);
        pc_write           = 1'b1;
        state_d            = S_FETCH;
      end
      default: ;
    endcase
  end

  // State, captured opcode/class, call depth, accelerator wait counter and trap cause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      opcode_q  <= '0;
      class_q   <= CL_NOP;
      acc_sel_q <= ACC_FFT;
      depth_q   <= '0;
      acc_cnt_q <= '0;
      cause_q   <= TC_NONE;
    end else begin
      state_q <= state_d;
      if (ir_load) opcode_q <= opcode;
      if (state_q == S_DECODE) begin
        class_q   <= dec_class;
        acc_sel_q <= dec_acc_sel;
      end
      if (stack_push)     depth_q <= depth_q + DEPTH_W'(1);
      else if (stack_pop) depth_q <= depth_q - DEPTH_W'(1);
      if (state_q == S_ACC && state_d == S_ACC) acc_cnt_q <= acc_cnt_q + CNT_W'(1);
      else                                      acc_cnt_q <= '0;
      if (state_d == S_TRAP && state_q != S_TRAP) cause_q <= cause_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - self-checking bench for the multi-cycle control unit
module tb_multicycle_control_unit;

  localparam int SD = 2;
  localparam int TO = 4;

  typedef struct packed {
    logic       ir_load;
    logic       rw;
    logic       mr;
    logic       mw;
    logic       alu_src;
    logic       m2r;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       push;
    logic       pop;
    logic       acc_start;
    logic [1:0] acc_sel;
    logic       trap;
    logic [1:0] cause;
    logic [1:0] depth;
  } ovec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [4:0] opcode = '0;
  logic       zero_flag = 1'b0;
  logic       mem_ready = 1'b0;
  logic       acc_done = 1'b0;
  logic       ir_load, register_write, memory_read, memory_write, alu_source;
  logic       memory_to_register, pc_write, stack_push, stack_pop, acc_start, trap;
  logic [1:0] pc_sel, acc_sel, trap_cause, call_depth;

  always #5 clk = ~clk;

  multicycle_control_unit #(.OPCODE_W(5), .STACK_DEPTH(SD), .ACC_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
    .zero_flag(zero_flag), .mem_ready(mem_ready), .acc_done(acc_done),
    .ir_load(ir_load), .register_write(register_write), .memory_read(memory_read),
    .memory_write(memory_write), .alu_source(alu_source),
    .memory_to_register(memory_to_register), .pc_write(pc_write), .pc_sel(pc_sel),
    .stack_push(stack_push), .stack_pop(stack_pop), .acc_start(acc_start),
    .acc_sel(acc_sel), .call_depth(call_depth), .trap(trap), .trap_cause(trap_cause)
  );

  int         n_tests = 0;
  int         n_fail = 0;
  int         m_depth = 0;
  bit         m_trap = 0;
  logic [1:0] m_cause = 2'd0;
  ovec_t      exp_q[$];
  bit         mr_q[$];
  bit         ad_q[$];

  function automatic ovec_t idle();
    ovec_t v = '0;
    v.depth = 2'(m_depth);
    v.trap  = m_trap;
    v.cause = m_cause;
    return v;
  endfunction

  function automatic ovec_t obs();
    ovec_t v;
    v = {ir_load, register_write, memory_read, memory_write, alu_source, memory_to_register,
         pc_write, pc_sel, stack_push, stack_pop, acc_start, acc_sel, trap, trap_cause, call_depth};
    return v;
  endfunction

  function automatic string kind(input logic [4:0] op);
    if (op == 5'd0) return "nop";
    if (op >= 5'd1 && op <= 5'd10) return "alu";
    case (op)
      5'd11: return "beq";
      5'd12: return "bne";
      5'd13: return "jump";
      5'd14: return "call";
      5'd15: return "ret";
      5'd16: return "load";
      5'd17: return "store";
      5'd18, 5'd19, 5'd20: return "acc";
      default: return "ill";
    endcase
  endfunction

  task automatic check(input ovec_t e, input string tag);
    ovec_t o = obs();
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // mr/ad: 1 or 0 forces that input in the cycle, -1 leaves it random
  task automatic add(input ovec_t v, input int mr, input int ad);
    exp_q.push_back(v);
    mr_q.push_back(mr < 0 ? bit'($urandom_range(0, 1)) : bit'(mr));
    ad_q.push_back(ad < 0 ? bit'($urandom_range(0, 1)) : bit'(ad));
  endtask

  // Reference: per-cycle expected outputs for one instruction, straight from the instruction rules
  task automatic build(input logic [4:0] op, input bit z, input int w, input int lat);
    ovec_t v;
    string k = kind(op);
    exp_q.delete(); mr_q.delete(); ad_q.delete();
    v = idle(); v.ir_load = 1; add(v, -1, -1);
    v = idle();
    if (k == "nop") begin v.pc_write = 1; add(v, -1, -1); return; end
    add(v, -1, -1);
    if (k == "ill") begin m_trap = 1; m_cause = 2'd1; return; end
    if (k == "acc") begin
      for (int i = 0; i <= TO; i++) begin
        v = idle(); v.acc_sel = 2'(op - 5'd18); v.acc_start = (i == 0);
        add(v, -1, (i == lat) ? 1 : 0);
        if (i == lat) begin v = idle(); v.rw = 1; v.pc_write = 1; add(v, -1, -1); return; end
      end
      m_trap = 1; m_cause = 2'd3; return;
    end
    v = idle();
    if (k == "alu") begin
      add(v, -1, -1);
      v = idle(); v.rw = 1; v.pc_write = 1; add(v, -1, -1);
    end else if (k == "load" || k == "store") begin
      v.alu_src = 1; add(v, -1, -1);
      for (int i = 0; i <= w; i++) begin
        v = idle(); v.alu_src = 1; v.mr = (k == "load"); v.mw = (k == "store");
        v.pc_write = (k == "store" && i == w);
        add(v, (i == w) ? 1 : 0, -1);
      end
      if (k == "load") begin v = idle(); v.rw = 1; v.m2r = 1; v.pc_write = 1; add(v, -1, -1); end
    end else if (k == "beq" || k == "bne" || k == "jump") begin
      v.pc_write = 1;
      v.pc_sel = (k == "jump" || (k == "beq" && z) || (k == "bne" && !z)) ? 2'd1 : 2'd0;
      add(v, -1, -1);
    end else if (k == "call") begin
      if (m_depth == SD) begin add(v, -1, -1); m_trap = 1; m_cause = 2'd2; end
      else begin v.push = 1; v.pc_write = 1; v.pc_sel = 2'd1; add(v, -1, -1); m_depth++; end
    end else begin
      if (m_depth == 0) begin add(v, -1, -1); m_trap = 1; m_cause = 2'd2; end
      else begin v.pop = 1; v.pc_write = 1; v.pc_sel = 2'd2; add(v, -1, -1); m_depth--; end
    end
  endtask

  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0; instr_valid = 1'b1; opcode = 5'($urandom); mem_ready = 1'b1; acc_done = 1'b1;
    #1 check('0, {tag, "_asserted"});
    m_depth = 0; m_trap = 0; m_cause = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; instr_valid = 1'b0;
    #1 check('0, {tag, "_released"});
  endtask

  task automatic run_op(input logic [4:0] op, input bit z, input int w, input int lat,
                        input int abort_at, input string tag);
    build(op, z, w, lat);
    for (int c = 0; c < exp_q.size(); c++) begin
      @(posedge clk); #1;
      instr_valid = (c == 0) ? 1'b1 : bit'($urandom_range(0, 1));
      opcode      = (c == 0) ? op : 5'($urandom);
      zero_flag   = z;
      mem_ready   = mr_q[c];
      acc_done    = ad_q[c];
      @(negedge clk);
      check(exp_q[c], $sformatf("%s_op%0d_c%0d", tag, op, c));
      if (c == abort_at) begin do_reset({tag, "_abort"}); return; end
    end
  endtask

  task automatic trap_hold(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      instr_valid = 1'b1; opcode = 5'($urandom); zero_flag = bit'($urandom_range(0, 1));
      mem_ready = bit'($urandom_range(0, 1)); acc_done = bit'($urandom_range(0, 1));
      @(negedge clk);
      check(idle(), $sformatf("%s_hold%0d", tag, c));
    end
  endtask

  initial begin
    do_reset("por");
    run_op(5'b00011, 1'b0, 0, 0, -1, "alu");
    run_op(5'b10000, 1'b0, 3, 0, -1, "load_wait3");
    run_op(5'b01011, 1'b1, 0, 0, -1, "beq_taken");
    run_op(5'b01100, 1'b1, 0, 0, -1, "bne_not_taken");
    run_op(5'b01100, 1'b0, 0, 0, -1, "bne_taken");
    run_op(5'b10001, 1'b0, 1, 0, -1, "store");
    run_op(5'b00000, 1'b0, 0, 0, -1, "nop");
    run_op(5'b01110, 1'b0, 0, 0, -1, "call1");
    run_op(5'b01110, 1'b0, 0, 0, -1, "call2");
    run_op(5'b01110, 1'b0, 0, 0, -1, "call3_overflow");
    trap_hold(3, "overflow");
    do_reset("rst_ovf");
    run_op(5'b01111, 1'b0, 0, 0, -1, "ret_underflow");
    trap_hold(3, "underflow");
    do_reset("rst_unf");
    run_op(5'b10010, 1'b0, 0, 99, -1, "fft_timeout");
    trap_hold(3, "timeout");
    do_reset("rst_to");
    run_op(5'b10010, 1'b0, 0, TO, -1, "fft_done_last");
    run_op(5'b10011, 1'b0, 0, 0, -1, "encrypt");
    run_op(5'b10100, 1'b0, 0, 2, -1, "decrypt");
    run_op(5'b11111, 1'b0, 0, 0, -1, "illegal");
    trap_hold(4, "illegal");
    do_reset("rst_ill");
    run_op(5'b01110, 1'b0, 0, 0, -1, "call_pre_abort");
    run_op(5'b10000, 1'b0, 5, 0, 4, "load_mid_mem");
    run_op(5'b00101, 1'b0, 0, 0, -1, "alu_after_abort");

    for (int n = 0; n < 80; n++) begin
      logic [4:0] op;
      if ($urandom_range(0, 9) == 0) op = 5'($urandom_range(21, 31));
      else                           op = 5'($urandom_range(0, 20));
      run_op(op, bit'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 5), -1, "rnd");
      if (m_trap) begin
        trap_hold(2, "rnd_trap");
        do_reset("rnd_rst");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
